// File: rtl/fifo_pkt_pkg.sv
// fifo_pkt_pkg: shared types for the packet FIFO.
//   wr_state_t - write-side FSM state:
//     IDLE    : no uncommitted words in the FIFO
//     IN_PKT  : at least one uncommitted word stored
//     DISCARD : packet overflowed, remaining words are swallowed
package fifo_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_PKT  = 2'd1,
        DISCARD = 2'd2
    } wr_state_t;

endpackage

// File: rtl/fifo_pkt_sync_sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port, one registered read port.
//   clk    - clock
//   reset  - synchronous active-low, clears only the read register
//   we     - write enable; waddr/wdata written on the rising edge
//   re     - read enable; rdata <= mem[raddr] on the rising edge, holds otherwise
//   rdata  - registered read data
module sdp_ram #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_pkt_sync.sv
// fifo_pkt_sync: synchronous packet FIFO with commit/discard semantics.
// Words become readable only once their packet is committed by wlast.
// A packet that overflows or is dropped by wdrop is rolled back.
//   clk, reset           - clock, synchronous active-low reset
//   wen/wdata/wlast      - write word, wlast commits the packet
//   wdrop                - discard the uncommitted packet
//   full/almost_full     - no free slot / free slots <= AFULL_MARGIN
//   drop                 - one-cycle pulse after a packet was discarded
//   ren                  - read request, honoured when !empty
//   rdata/rlast/rvalid   - read word, its last flag, valid the cycle after ren
//   empty                - no committed word readable
//   pkt_count            - committed packets not yet fully read
//   level                - occupied slots including uncommitted words
module fifo_pkt_sync
    import fifo_pkt_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 11,
    parameter int unsigned W_EL         = 20,
    parameter int unsigned AFULL_MARGIN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wen,
    input  logic [W_EL-1:0]       wdata,
    input  logic                  wlast,
    input  logic                  wdrop,
    output logic                  full,
    output logic                  almost_full,
    output logic                  drop,
    input  logic                  ren,
    output logic [W_EL-1:0]       rdata,
    output logic                  rlast,
    output logic                  rvalid,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   pkt_count,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int unsigned   PW       = ADDR_WIDTH + 1;
    localparam int unsigned   DEPTH    = 2**ADDR_WIDTH;
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] MARGIN_P = PW'(AFULL_MARGIN);

    wr_state_t     state, state_n;
    logic [PW-1:0] wptr, cptr, rptr;
    logic [PW-1:0] wptr_n, cptr_n, rptr_n, level_n;
    logic [PW-1:0] pkt_q;
    logic          full_q, empty_q, afull_q, drop_q, rvalid_q;
    logic          wr_en, commit, drop_n, rd_en, rd_last;
    logic [W_EL:0] ram_dout;

    // Copy of the last flags in flops so a packet's read-out is accounted
    // on the same edge the read is accepted, not when the RAM data returns.
    logic [DEPTH-1:0] last_flags;

    always_comb begin
        state_n = state;
        wptr_n  = wptr;
        cptr_n  = cptr;
        wr_en   = 1'b0;
        commit  = 1'b0;
        drop_n  = 1'b0;
        unique case (state)
            IDLE, IN_PKT: begin
                if (wdrop) begin
                    wptr_n  = cptr;
                    drop_n  = 1'b1;
                    state_n = IDLE;
                end else if (wen && full_q) begin
                    wptr_n  = cptr;
                    drop_n  = 1'b1;
                    state_n = wlast ? IDLE : DISCARD;
                end else if (wen) begin
                    wr_en  = 1'b1;
                    wptr_n = wptr + 1'b1;
                    if (wlast) begin
                        cptr_n  = wptr + 1'b1;
                        commit  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = IN_PKT;
                    end
                end
            end
            DISCARD: begin
                if (wdrop || (wen && wlast))
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign rd_en   = ren && !empty_q;
    assign rd_last = rd_en && last_flags[rptr[ADDR_WIDTH-1:0]];
    assign rptr_n  = rptr + PW'(rd_en);
    assign level_n = wptr_n - rptr_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            wptr     <= '0;
            cptr     <= '0;
            rptr     <= '0;
            pkt_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            drop_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state    <= state_n;
            wptr     <= wptr_n;
            cptr     <= cptr_n;
            rptr     <= rptr_n;
            empty_q  <= (rptr_n == cptr_n);
            full_q   <= (level_n == DEPTH_P);
            afull_q  <= ((DEPTH_P - level_n) <= MARGIN_P);
            drop_q   <= drop_n;
            rvalid_q <= rd_en;
            if (commit && !rd_last)
                pkt_q <= pkt_q + 1'b1;
            else if (!commit && rd_last)
                pkt_q <= pkt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            last_flags[wptr[ADDR_WIDTH-1:0]] <= wlast;
    end

    sdp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (W_EL + 1)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .waddr (wptr[ADDR_WIDTH-1:0]),
        .wdata ({wlast, wdata}),
        .re    (rd_en),
        .raddr (rptr[ADDR_WIDTH-1:0]),
        .rdata (ram_dout)
    );

    assign full        = full_q;
    assign almost_full = afull_q;
    assign drop        = drop_q;
    assign empty       = empty_q;
    assign rvalid      = rvalid_q;
    assign rdata       = ram_dout[W_EL-1:0];
    assign rlast       = ram_dout[W_EL];
    assign pkt_count   = pkt_q;
    assign level       = wptr - rptr;

endmodule

// File: tb/tb_fifo_pkt_sync.sv
// tb_fifo_pkt_sync: directed self-checking bench for fifo_pkt_sync
// with ADDR_WIDTH=4, W_EL=8, AFULL_MARGIN=4.
module tb_fifo_pkt_sync;

    logic       clk;
    logic       reset;
    logic       wen;
    logic [7:0] wdata;
    logic       wlast;
    logic       wdrop;
    logic       full;
    logic       almost_full;
    logic       drop;
    logic       ren;
    logic [7:0] rdata;
    logic       rlast;
    logic       rvalid;
    logic       empty;
    logic [4:0] pkt_count;
    logic [4:0] level;

    int n_cmp = 0;
    int n_err = 0;

    fifo_pkt_sync #(
        .ADDR_WIDTH   (4),
        .W_EL         (8),
        .AFULL_MARGIN (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wen         (wen),
        .wdata       (wdata),
        .wlast       (wlast),
        .wdrop       (wdrop),
        .full        (full),
        .almost_full (almost_full),
        .drop        (drop),
        .ren         (ren),
        .rdata       (rdata),
        .rlast       (rlast),
        .rvalid      (rvalid),
        .empty       (empty),
        .pkt_count   (pkt_count),
        .level       (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen   = 1'b0;
        wdata = '0;
        wlast = 1'b0;
        wdrop = 1'b0;
        ren   = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_empty"},  32'(empty),       32'd1);
        chk({tag, "_full"},   32'(full),        32'd0);
        chk({tag, "_afull"},  32'(almost_full), 32'd0);
        chk({tag, "_drop"},   32'(drop),        32'd0);
        chk({tag, "_rvalid"}, 32'(rvalid),      32'd0);
        chk({tag, "_rdata"},  32'(rdata),       32'd0);
        chk({tag, "_rlast"},  32'(rlast),       32'd0);
        chk({tag, "_pkt"},    32'(pkt_count),   32'd0);
        chk({tag, "_level"},  32'(level),       32'd0);
    endtask

    initial begin
        idle();
        reset = 1'b0;
        step();
        step();
        chk_reset_state("rst");
        reset = 1'b1;

        // 3-word packet, then read it out
        wen = 1'b1; wdata = 8'h11; step();
        chk("p3_w1_level", 32'(level), 32'd1);
        chk("p3_w1_empty", 32'(empty), 32'd1);
        wdata = 8'h22; step();
        chk("p3_w2_empty", 32'(empty), 32'd1);
        wdata = 8'h33; wlast = 1'b1; step();
        chk("p3_commit_empty", 32'(empty), 32'd0);
        chk("p3_commit_pkt", 32'(pkt_count), 32'd1);
        chk("p3_commit_level", 32'(level), 32'd3);
        idle();
        ren = 1'b1; step();
        chk("p3_r1_rvalid", 32'(rvalid), 32'd1);
        chk("p3_r1_rdata", 32'(rdata), 32'h11);
        chk("p3_r1_rlast", 32'(rlast), 32'd0);
        chk("p3_r1_pkt", 32'(pkt_count), 32'd1);
        step();
        chk("p3_r2_rdata", 32'(rdata), 32'h22);
        chk("p3_r2_rlast", 32'(rlast), 32'd0);
        step();
        chk("p3_r3_rdata", 32'(rdata), 32'h33);
        chk("p3_r3_rlast", 32'(rlast), 32'd1);
        chk("p3_r3_pkt", 32'(pkt_count), 32'd0);
        chk("p3_r3_empty", 32'(empty), 32'd1);
        idle(); step();
        chk("p3_hold_rvalid", 32'(rvalid), 32'd0);
        chk("p3_hold_rdata", 32'(rdata), 32'h33);

        // Two words, then wdrop alongside a write
        wen = 1'b1; wdata = 8'h44; step();
        wdata = 8'h55; step();
        chk("drp_level_pre", 32'(level), 32'd2);
        wdata = 8'h66; wdrop = 1'b1; step();
        chk("drp_pulse", 32'(drop), 32'd1);
        chk("drp_level", 32'(level), 32'd0);
        chk("drp_empty", 32'(empty), 32'd1);
        idle(); step();
        chk("drp_pulse_end", 32'(drop), 32'd0);
        chk("drp_empty2", 32'(empty), 32'd1);

        // 20-word packet overflows a 16-deep FIFO
        for (int i = 1; i <= 20; i++) begin
            wen = 1'b1; wdata = 8'(i); wlast = (i == 20);
            step();
            if (i == 11) chk("ovf_afull_11", 32'(almost_full), 32'd0);
            if (i == 12) chk("ovf_afull_12", 32'(almost_full), 32'd1);
            if (i == 15) chk("ovf_full_15", 32'(full), 32'd0);
            if (i == 16) begin
                chk("ovf_full_16", 32'(full), 32'd1);
                chk("ovf_level_16", 32'(level), 32'd16);
                chk("ovf_drop_16", 32'(drop), 32'd0);
            end
            if (i == 17) begin
                chk("ovf_drop_17", 32'(drop), 32'd1);
                chk("ovf_level_17", 32'(level), 32'd0);
                chk("ovf_full_17", 32'(full), 32'd0);
            end
            if (i >= 18) begin
                chk("ovf_drop_tail", 32'(drop), 32'd0);
                chk("ovf_level_tail", 32'(level), 32'd0);
            end
        end
        chk("ovf_pkt", 32'(pkt_count), 32'd0);
        chk("ovf_empty", 32'(empty), 32'd1);
        wen = 1'b1; wdata = 8'hA5; wlast = 1'b1; step();
        chk("ovf_next_empty", 32'(empty), 32'd0);
        chk("ovf_next_pkt", 32'(pkt_count), 32'd1);
        idle(); ren = 1'b1; step();
        chk("ovf_next_rdata", 32'(rdata), 32'hA5);
        chk("ovf_next_rlast", 32'(rlast), 32'd1);
        chk("ovf_next_pkt0", 32'(pkt_count), 32'd0);
        idle(); step();

        // 12-word packet, almost_full, then read/commit in the same cycle
        for (int i = 1; i <= 12; i++) begin
            wen = 1'b1; wdata = 8'(8'h30 + i); wlast = (i == 12);
            step();
            if (i == 11) chk("af_11", 32'(almost_full), 32'd0);
        end
        chk("af_12", 32'(almost_full), 32'd1);
        chk("af_level", 32'(level), 32'd12);
        chk("af_pkt", 32'(pkt_count), 32'd1);
        idle();
        for (int i = 1; i <= 11; i++) begin
            ren = 1'b1; step();
            chk("af_rd_data", 32'(rdata), 32'(8'h30 + i));
        end
        chk("af_pkt_pre", 32'(pkt_count), 32'd1);
        ren = 1'b1; wen = 1'b1; wdata = 8'h77; wlast = 1'b1; step();
        chk("rc_pkt", 32'(pkt_count), 32'd1);
        chk("rc_rdata", 32'(rdata), 32'h3C);
        chk("rc_rlast", 32'(rlast), 32'd1);
        chk("rc_level", 32'(level), 32'd1);
        chk("rc_empty", 32'(empty), 32'd0);
        idle(); ren = 1'b1; step();
        chk("rc_new_rdata", 32'(rdata), 32'h77);
        chk("rc_new_pkt", 32'(pkt_count), 32'd0);
        chk("rc_new_empty", 32'(empty), 32'd1);
        idle(); step();

        // 40 single-word packets streamed with concurrent reads (pointers wrap)
        for (int k = 0; k < 40; k++) begin
            wen = 1'b1; wdata = 8'(8'h80 + k); wlast = 1'b1; ren = 1'b1;
            step();
            if (k == 0) begin
                chk("str_first_rvalid", 32'(rvalid), 32'd0);
            end else begin
                chk("str_rvalid", 32'(rvalid), 32'd1);
                chk("str_rdata", 32'(rdata), 32'(8'h80 + k - 1));
            end
            chk("str_pkt", 32'(pkt_count), 32'd1);
            chk("str_empty", 32'(empty), 32'd0);
            chk("str_full", 32'(full), 32'd0);
        end
        idle(); ren = 1'b1; step();
        chk("str_tail_rdata", 32'(rdata), 32'hA7);
        chk("str_tail_empty", 32'(empty), 32'd1);
        chk("str_tail_pkt", 32'(pkt_count), 32'd0);

        // Reset mid-packet with a committed packet also present
        idle();
        wen = 1'b1; wdata = 8'hC1; wlast = 1'b1; step();
        wlast = 1'b0; wdata = 8'hC2; step();
        wdata = 8'hC3; step();
        chk("mid_level", 32'(level), 32'd3);
        chk("mid_pkt", 32'(pkt_count), 32'd1);
        wdata = 8'hC4; ren = 1'b1; reset = 1'b0; step();
        chk_reset_state("mid_rst");
        idle(); reset = 1'b1; step();
        chk("post_rst_empty", 32'(empty), 32'd1);
        wen = 1'b1; wdata = 8'h5A; wlast = 1'b1; step();
        idle(); ren = 1'b1; step();
        chk("post_rst_rdata", 32'(rdata), 32'h5A);
        chk("post_rst_rlast", 32'(rlast), 32'd1);
        chk("post_rst_level", 32'(level), 32'd0);
        idle(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_pkt_sync.md
FIFO_PKT_SYNC -- requirements
Module: fifo_pkt_sync

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11: depth = 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter W_EL, default 20: data word width; each stored entry is W_EL+1 bits (data plus last flag).
REQ-003 SHALL have parameter AFULL_MARGIN, default 4: almost_full asserts when free slots <= AFULL_MARGIN.
REQ-004 SHALL have one clock, clk, and a synchronous active-low reset named reset: the block resets on a clk rising edge while reset==0.
REQ-005 Ports SHALL be, in this order:
  clk  in  1  clock
  reset  in  1  synchronous, active-low
  wen  in  1  write word strobe
  wdata  in  W_EL  write word
  wlast  in  1  word is end of packet (commit)
  wdrop  in  1  discard the uncommitted packet
  full  out  1  no free slot
  almost_full  out  1  free slots <= AFULL_MARGIN
  drop  out  1  one-cycle pulse: a packet was discarded
  ren  in  1  read request
  rdata  out  W_EL  read word
  rlast  out  1  rdata is last word of its packet
  rvalid  out  1  rdata/rlast valid this cycle
  empty  out  1  no committed word readable
  pkt_count  out  ADDR_WIDTH+1  committed, not fully read packets
  level  out  ADDR_WIDTH+1  occupied slots, uncommitted words included

Function
REQ-006 SHALL keep pointers wptr (speculative), cptr (commit) and rptr, each ADDR_WIDTH+1 bits, with MSB wrap for full/empty disambiguation; arithmetic is modulo 2**(ADDR_WIDTH+1).
REQ-007 Accepted write (wen && !full && state!=DISCARD && !wdrop) SHALL store {wlast,wdata} at wptr and increment wptr.
REQ-008 An accepted write with wlast SHALL set cptr to the new wptr and increment pkt_count in the same edge.
REQ-009 The write FSM SHALL have states IDLE (no uncommitted words), IN_PKT (>=1 uncommitted word) and DISCARD (overflowed packet being swallowed).
REQ-010 IDLE->IN_PKT on accepted write without wlast. IN_PKT->IDLE on accepted write with wlast.
REQ-011 wdrop in IDLE or IN_PKT SHALL set wptr=cptr, ignore the same-cycle wen/wdata, pulse drop, and go to IDLE. wdrop beats wlast.
REQ-012 wen while full in IDLE or IN_PKT SHALL set wptr=cptr, pulse drop, and go to DISCARD; if that word has wlast, go to IDLE instead.
REQ-013 In DISCARD, all words SHALL be ignored; wen&&wlast or wdrop returns to IDLE with no further drop pulse.
REQ-014 Accepted read (ren && !empty) SHALL return the entry at rptr with rvalid=1 on the next cycle and increment rptr; rdata/rlast hold their value when rvalid=0.
REQ-015 An accepted read of an entry with last=1 SHALL decrement pkt_count; a commit and a last-read in the same cycle SHALL leave pkt_count unchanged.
REQ-016 empty SHALL be registered and equal (next_rptr==next_cptr); full SHALL be registered and equal (next_wptr-next_rptr == 2**ADDR_WIDTH); level=wptr-rptr.
REQ-017 A read in the same cycle as a commit SHALL see only previously committed data; new data is readable the cycle after commit.
REQ-018 A packet longer than the depth SHALL always be dropped via REQ-012 and SHALL never deadlock.

Reset
REQ-019 On reset SHALL set wptr=cptr=rptr=0, state=IDLE, empty=1, full=0, almost_full=0, drop=0, rvalid=0, rdata=0, rlast=0, pkt_count=0, level=0; RAM contents are not reset. Reset mid-packet discards all data with no drop pulse.

Structure
REQ-020 Package fifo_pkt_pkg SHALL hold the FSM state enum (IDLE, IN_PKT, DISCARD).
REQ-021 Storage SHALL be one sub-module, sdp_ram (simple dual-port, registered read, W_EL+1 wide, 2**ADDR_WIDTH deep).

Verification (ADDR_WIDTH=4, W_EL=8, AFULL_MARGIN=4)
REQ-022 Write 3-word packet 0x11,0x22,0x33(wlast), then read 3 -> empty falls the cycle after commit; rdata 0x11,0x22,0x33 with rlast only on 0x33; pkt_count 1->0.
REQ-023 Write 2 words, then wdrop alongside a wen -> drop pulses once, level returns to 0, empty stays 1.
REQ-024 Write a 20-word packet -> full at word 16, drop pulses at word 17, words 18-20 ignored, level 0 after; a following 1-word packet reads back correctly.
REQ-025 Fill 12 committed words -> almost_full=1 at level 12; read/commit in the same cycle with pkt_count=1 -> pkt_count stays 1.
REQ-026 Pointer wrap: 40 single-word packets streamed with concurrent reads -> data in order, no spurious full/empty; assert reset=0 mid-packet -> all outputs at REQ-019 values next cycle.
